// File: rtl/uart_pkg.sv
// Shared constants for the UART frame receiver: FSM encoding, parity modes,
// the default end-of-transmission code and the 3-sample majority helper.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        BREAK  = ST_BREAK
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [7:0] EOT_CHAR_DEFAULT = 8'h04;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Word-level output bundle of the frame receiver towards the command/data FIFO.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 eot;
    logic                 busy;

    modport master (
        output data_out, data_valid, parity_err, frame_err, eot, busy
    );

    modport slave (
        input data_out, data_valid, parity_err, frame_err, eot, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the rx pin plus a 3-sample majority voter
// around the bit midpoint (early and mid samples stored, late sample live).
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic baud_tick,
    input  logic sample_early,
    input  logic sample_mid,
    output logic rxs,
    output logic vote
);

    logic meta;
    logic early_q;
    logic mid_q;

    // NOTE: the synchroniser and sample flops reset to 1 (line idle level) so
    // reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta    <= 1'b1;
            rxs     <= 1'b1;
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else begin
            meta <= rx;
            rxs  <= meta;
            if (baud_tick && sample_early) early_q <= rxs;
            if (baud_tick && sample_mid)   mid_q   <= rxs;
        end
    end

    assign vote = maj3(early_q, mid_q, rxs);

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: deframes start/data/parity/stop on an oversampling
// baud_tick and emits one word per frame with parity, framing and EOT flags.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int         DATA_BITS   = 8,
    parameter int         OVERSAMPLE  = 16,
    parameter int         PARITY_MODE = PARITY_NONE,
    parameter int         STOP_BITS   = 1,
    parameter logic [7:0] EOT_CHAR    = EOT_CHAR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            baud_tick,
    input  logic            rx,
    uart_rx_frame_if.master frame
);

    localparam int TC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS + 1);
    localparam int EOT_W = (DATA_BITS < 8) ? DATA_BITS : 8;

    localparam logic [TC_W-1:0] TC_ONE   = TC_W'(1);
    localparam logic [TC_W-1:0] TC_EARLY = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0] TC_MID   = TC_W'(OVERSAMPLE / 2);
    localparam logic [TC_W-1:0] TC_LATE  = TC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TC_W-1:0] TC_LAST  = TC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(DATA_BITS - 1);
    localparam logic            SC_LAST  = 1'(STOP_BITS - 1);
    localparam logic            ODD_PAR  = (PARITY_MODE == PARITY_ODD);

    state_t                 state;
    state_t                 state_nxt;
    logic [TC_W-1:0]        tc;
    logic [BC_W-1:0]        bit_cnt;
    logic                   stop_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   stop_err;
    logic                   par_err_q;
    logic                   rxs;
    logic                   vote;
    logic                   tick_mid;
    logic                   tick_late;
    logic                   tick_last;
    logic                   start_seen;
    logic                   done;
    logic                   frame_bad;

    uart_rx_sampler u_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .baud_tick    (baud_tick),
        .sample_early (tc == TC_EARLY),
        .sample_mid   (tc == TC_MID),
        .rxs          (rxs),
        .vote         (vote)
    );

    assign tick_mid   = baud_tick && (tc == TC_MID);
    assign tick_late  = baud_tick && (tc == TC_LATE);
    assign tick_last  = baud_tick && (tc == TC_LAST);
    assign start_seen = (state == IDLE) && !rxs;

    // NOTE: state register uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is defaulted first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        frame_bad = stop_err | ~vote;
        case (state)
            IDLE:   if (!rxs) state_nxt = START;
            START: begin
                if (tick_mid && rxs) state_nxt = IDLE;
                else if (tick_last)  state_nxt = DATA;
            end
            DATA: begin
                if (tick_last && (bit_cnt == BC_LAST))
                    state_nxt = (PARITY_MODE == PARITY_NONE) ? STOP : PARITY;
            end
            PARITY: if (tick_last) state_nxt = STOP;
            STOP: begin
                // The frame closes at the late sample of the last stop bit so a
                // start edge early in the following bit period is still caught.
                if (tick_late && (stop_cnt == SC_LAST)) begin
                    done      = 1'b1;
                    state_nxt = frame_bad ? BREAK : IDLE;
                end
            end
            BREAK:  if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc               <= '0;
            bit_cnt          <= '0;
            stop_cnt         <= 1'b0;
            shreg            <= '0;
            stop_err         <= 1'b0;
            par_err_q        <= 1'b0;
            frame.data_out   <= '0;
            frame.data_valid <= 1'b0;
            frame.parity_err <= 1'b0;
            frame.frame_err  <= 1'b0;
            frame.eot        <= 1'b0;
        end else begin
            frame.data_valid <= done;

            // A tick coinciding with start detection already counts for START.
            if (start_seen)     tc <= baud_tick ? TC_ONE : '0;
            else if (baud_tick) tc <= (tc == TC_LAST) ? '0 : tc + 1'b1;

            if (start_seen) begin
                stop_cnt  <= 1'b0;
                stop_err  <= 1'b0;
                par_err_q <= 1'b0;
            end

            if (state == START && tick_last)                 bit_cnt <= '0;
            else if (state == DATA && tick_last)             bit_cnt <= bit_cnt + 1'b1;

            if (state == DATA && tick_late)   shreg     <= {vote, shreg[DATA_BITS-1:1]};
            if (state == PARITY && tick_late) par_err_q <= vote ^ (^shreg) ^ ODD_PAR;
            if (state == STOP && tick_late)   stop_err  <= stop_err | ~vote;
            if (state == STOP && tick_last)   stop_cnt  <= stop_cnt + 1'b1;

            if (done) begin
                frame.data_out   <= shreg;
                frame.parity_err <= par_err_q;
                frame.frame_err  <= frame_bad;
                frame.eot        <= (shreg[EOT_W-1:0] == EOT_CHAR[EOT_W-1:0])
                                    && !par_err_q && !frame_bad;
            end
        end
    end

    assign frame.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8N1 instance and an 8E1 instance
// driven bit by bit on a baud_tick every 4 clk (16 ticks per bit).
module tb_uart_rx_frame;
    import uart_pkg::*;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic baud_tick = 1'b0;
    logic rx0       = 1'b1;
    logic rx1       = 1'b1;

    int checks = 0;
    int errors = 0;

    int         vcnt0 = 0;
    int         vcnt1 = 0;
    logic [7:0] cap0_data;
    logic       cap0_eot;
    logic       cap0_ferr;
    logic [7:0] cap1_data;
    logic       cap1_perr;
    logic       cap1_ferr;

    uart_rx_frame_if #(.DATA_BITS(8)) f0 ();
    uart_rx_frame_if #(.DATA_BITS(8)) f1 ();

    uart_rx_frame #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(PARITY_NONE),
        .STOP_BITS(1), .EOT_CHAR(8'h04)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx0), .frame(f0)
    );

    uart_rx_frame #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(PARITY_EVEN),
        .STOP_BITS(1), .EOT_CHAR(8'h04)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .rx(rx1), .frame(f1)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
        end
    end

    // Record every data_valid cycle together with the flags seen on it.
    always @(negedge clk) begin
        if (f0.data_valid) begin
            vcnt0     <= vcnt0 + 1;
            cap0_data <= f0.data_out;
            cap0_eot  <= f0.eot;
            cap0_ferr <= f0.frame_err;
        end
        if (f1.data_valid) begin
            vcnt1     <= vcnt1 + 1;
            cap1_data <= f1.data_out;
            cap1_perr <= f1.parity_err;
            cap1_ferr <= f1.frame_err;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int ch, input logic v);
        if (ch == 0) rx0 = v;
        else         rx1 = v;
    endtask

    task automatic send_bit(input int ch, input logic v);
        drive(ch, v);
        wait_ticks(16);
    endtask

    task automatic send_frame(input int ch, input logic [7:0] d, input bit use_par,
                              input logic par, input logic stop);
        send_bit(ch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(ch, d[i]);
        if (use_par) send_bit(ch, par);
        send_bit(ch, stop);
    endtask

    initial begin
        logic [7:0] d;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out",   f0.data_out,   32'h0);
        check("rst_data_valid", f0.data_valid, 32'h0);
        check("rst_parity_err", f0.parity_err, 32'h0);
        check("rst_frame_err",  f0.frame_err,  32'h0);
        check("rst_eot",        f0.eot,        32'h0);
        check("rst_busy0",      f0.busy,       32'h0);
        check("rst_busy1",      f1.busy,       32'h0);
        rst_n = 1'b1;
        wait_ticks(2);

        // 1: 0x55 then 0x04 back to back
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        check("t1_cnt_a",  vcnt0,     32'd1);
        check("t1_data_a", cap0_data, 32'h55);
        check("t1_eot_a",  cap0_eot,  32'h0);
        check("t1_ferr_a", cap0_ferr, 32'h0);
        send_frame(0, 8'h04, 1'b0, 1'b0, 1'b1);
        check("t1_cnt_b",   vcnt0,         32'd2);
        check("t1_data_b",  cap0_data,     32'h04);
        check("t1_eot_b",   cap0_eot,      32'h1);
        check("t1_eot_hold", f0.eot,       32'h1);
        check("t1_dv_low",  f0.data_valid, 32'h0);
        check("t1_idle",    f0.busy,       32'h0);

        // 2: even parity, correct then wrong parity bit
        send_frame(1, 8'hA3, 1'b1, 1'b0, 1'b1);
        check("t2_cnt_a",  vcnt1,     32'd1);
        check("t2_data_a", cap1_data, 32'hA3);
        check("t2_perr_a", cap1_perr, 32'h0);
        send_frame(1, 8'hA3, 1'b1, 1'b1, 1'b1);
        check("t2_cnt_b",  vcnt1,     32'd2);
        check("t2_data_b", cap1_data, 32'hA3);
        check("t2_perr_b", cap1_perr, 32'h1);
        check("t2_ferr_b", cap1_ferr, 32'h0);
        check("t2_perr_hold", f1.parity_err, 32'h1);

        // 3: false start, low for 5 ticks
        drive(0, 1'b0);
        wait_ticks(3);
        check("t3_busy_start", f0.busy, 32'h1);
        wait_ticks(2);
        drive(0, 1'b1);
        wait_ticks(3);
        check("t3_busy_pre_mid", f0.busy, 32'h1);
        wait_ticks(1);
        check("t3_busy_mid", f0.busy, 32'h0);
        wait_ticks(8);
        check("t3_no_output", vcnt0, 32'd2);
        send_frame(0, 8'hC5, 1'b0, 1'b0, 1'b1);
        check("t3_cnt",  vcnt0,     32'd3);
        check("t3_data", cap0_data, 32'hC5);

        // 5: one-tick spike at the midpoint of bit 3 of 0x0F
        d = 8'h0F;
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, d[i]);
        drive(0, d[3]);
        wait_ticks(8);
        drive(0, ~d[3]);
        wait_ticks(1);
        drive(0, d[3]);
        wait_ticks(7);
        for (int i = 4; i < 8; i++) send_bit(0, d[i]);
        send_bit(0, 1'b1);
        check("t5_cnt",  vcnt0,     32'd4);
        check("t5_data", cap0_data, 32'h0F);

        // 4: stop bit 0 and line held low for three frame times
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_ticks(3 * 160);
        check("t4_cnt",   vcnt0,        32'd5);
        check("t4_data",  cap0_data,    32'h00);
        check("t4_ferr",  cap0_ferr,    32'h1);
        check("t4_eot",   cap0_eot,     32'h0);
        check("t4_ferr_hold", f0.frame_err, 32'h1);
        check("t4_break_busy", f0.busy, 32'h1);
        drive(0, 1'b1);
        wait_ticks(2);
        check("t4_idle",     f0.busy, 32'h0);
        check("t4_no_extra", vcnt0,   32'd5);
        send_frame(0, 8'h04, 1'b0, 1'b0, 1'b1);
        check("t4_next_cnt",  vcnt0,     32'd6);
        check("t4_next_eot",  cap0_eot,  32'h1);
        check("t4_next_ferr", cap0_ferr, 32'h0);

        // 6: reset in the middle of bit 4 of 0xFF
        d = 8'hFF;
        send_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, d[i]);
        drive(0, d[4]);
        wait_ticks(8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_data_out", f0.data_out, 32'h0);
        check("t6_eot",      f0.eot,      32'h0);
        check("t6_busy",     f0.busy,     32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(8);
        for (int i = 5; i < 8; i++) send_bit(0, d[i]);
        send_bit(0, 1'b1);
        check("t6_no_partial", vcnt0,   32'd6);
        check("t6_idle",       f0.busy, 32'h0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        check("t6_cnt",  vcnt0,     32'd7);
        check("t6_data", cap0_data, 32'h3C);
        check("t6_eot",  cap0_eot,  32'h0);
        check("t6_ferr", cap0_ferr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
